uop_minterm_sequencer: RTL and testbench
========================================

# uop_minterm_sequencer

Synthesizable self-test stage that sits directly upstream of a small combinational DUT, such as the 2-input `uop_nxor`. It walks every input minterm onto the DUT inputs and waits a programmable settle time. It then samples the DUT output against a parameterised truth table. It reports pass/fail, an error count and the first failing minterm through a start/busy/done handshake, so gate labs can be self-checked in hardware as well as in simulation.

## Interface
Parameters:
- `N_IN`, 2: DUT input width; minterms 0 .. 2^N_IN-1.
- `TRUTH`, 4'b1001: expected DUT output, bit k for minterm k (default is XNOR); width 2^N_IN.
- `SETTLE`, 2: clock cycles the DUT inputs are held before sampling; legal range ≥1.
- `ERR_W`, 3: width of the error counter.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: run request, sampled on the clock edge.
- `dut_in`, out, N_IN: minterm driven to the DUT; MSB maps to the first DUT input (`{aa,bb}` order).
- `dut_out`, in, 1: DUT output being checked.
- `busy`, out, 1: run in progress.
- `done`, out, 1: run complete; results valid.
- `pass`, out, 1: `done` && `err_count`==0.
- `err_count`, out, ERR_W: number of mismatching minterms; saturates at 2^ERR_W-1.
- `fail_valid`, out, 1: at least one mismatch recorded.
- `fail_mt`, out, N_IN: first failing minterm; valid when `fail_valid`=1.

## Operation
- FSM states: IDLE, WAIT, CHECK, FIN.
- Reset (asynchronous, any state): state=IDLE, minterm=0, settle count=0. All outputs are 0: `dut_in`, `busy`, `done`, `pass`, `err_count`, `fail_valid`, `fail_mt`.
- IDLE or FIN with `start`=1: clear `err_count`, `fail_valid`, `fail_mt` and `done`; minterm=0; `dut_in`=0; `busy`=1; go to WAIT.
- WAIT: hold `dut_in`. Stay for exactly SETTLE cycles, then go to CHECK.
- CHECK, one cycle: compare `dut_out` with TRUTH[minterm].
  - On mismatch: increment `err_count` (saturating). If `fail_valid`=0, set `fail_mt`=minterm and `fail_valid`=1.
  - If minterm = 2^N_IN-1, go to FIN.
  - Otherwise increment minterm, update `dut_in`, and go to WAIT.
- FIN: `busy`=0 and `done`=1. Results hold until the next accepted `start` or reset.
- `start` while `busy`=1 is ignored, with no restart and no side effect.
- The minterm counter never wraps during a run. The last minterm exits to FIN.

## Timing
- E0 is the edge at which `start` is accepted. `dut_in`=0 and `busy`=1 are visible after E0.
- Minterm k is sampled at edge E0+(k+1)(SETTLE+1). `dut_in` changes to k+1 after that same edge.
- For the defaults (N_IN=2, SETTLE=2), samples occur at E3, E6, E9 and E12.
- `done`=1 and `busy`=0 after the final sample edge, E0+2^N_IN·(SETTLE+1). That is E12 for the defaults.
- `err_count`, `fail_*` and `pass` are registered. They update on the sample edge and are stable from `done`.
- `dut_out` is treated as synchronous to `clk`; there is no synchroniser.
- `busy` and `done` are never 1 together.

## Structure
- Package `uop_test_pkg`: the FSM state enum (IDLE, WAIT, CHECK, FIN) and a `localparam` for the minterm count 2^N_IN, derived in the module.
- A single flat module; no sub-module is needed. The settle counter and the minterm counter are inline registers.
- The integration bench instantiates `uop_minterm_sequencer` driving `uop_nxor`.

## Test plan
- XNOR DUT, defaults, `start` pulsed one cycle -> `dut_in` steps 0,1,2,3. Samples occur at E3, E6, E9, E12. After E12: `done`=1, `pass`=1, `err_count`=0, `fail_valid`=0.
- XOR DUT substituted -> `err_count`=4, `fail_valid`=1, `fail_mt`=0, `pass`=0.
- DUT output stuck at 1 -> `err_count`=2, `fail_mt`=1. Stuck at 0 -> `err_count`=2, `fail_mt`=0.
- `start` held high for the whole run -> a single run completes at E12. A new run begins at E13 (from FIN) with results cleared and `done`=0.
- `reset` asserted asynchronously between edges at E7 -> all outputs go to 0 immediately. A subsequent `start` produces a clean full run with `pass`=1.
- ERR_W=1 with the XOR DUT -> `err_count` saturates at 1, `fail_mt`=0, `pass`=0.

Source files
------------

// File: rtl/uop_test_pkg.sv
// Shared types for the minterm self-test sequencer.
package uop_test_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StCheck = 2'd2,
    StFin   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/uop_minterm_sequencer.sv
// Walks every input minterm onto a small combinational DUT, waits a settle time, checks the
// sampled output against a truth table and reports pass/fail, error count and first failure.
module uop_minterm_sequencer
  import uop_test_pkg::*;
#(
  parameter int unsigned        N_IN   = 2,
  parameter logic [2**N_IN-1:0] TRUTH  = 4'b1001,
  parameter int unsigned        SETTLE = 2,
  parameter int unsigned        ERR_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [N_IN-1:0]  fail_mt
);

  localparam int unsigned       NumMt   = 2 ** N_IN;
  localparam int unsigned       CntW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0]   CntLast = CntW'(SETTLE - 1);
  localparam logic [N_IN-1:0]   MtLast  = N_IN'(NumMt - 1);
  localparam logic [ERR_W-1:0]  ErrMax  = '1;

  seq_state_e       state_q, state_d;
  logic [N_IN-1:0]  mt_q, mt_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [N_IN-1:0]  fmt_q, fmt_d;
  logic             mismatch;

  // dut_out is combinational from dut_in, which only changes on the sample edge.
  assign mismatch = (dut_out != TRUTH[mt_q]);

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fmt_d   = fmt_q;

    case (state_q)
      StIdle, StFin: begin
        if (start) begin
          state_d = StWait;
          mt_d    = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fv_d    = 1'b0;
          fmt_d   = '0;
        end
      end
      StWait: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q != ErrMax) begin
            err_d = err_q + 1'b1;
          end
          if (!fv_q) begin
            fv_d  = 1'b1;
            fmt_d = mt_q;
          end
        end
        if (mt_q == MtLast) begin
          state_d = StFin;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          mt_d    = mt_q + 1'b1;
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      mt_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fmt_q   <= '0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fmt_q   <= fmt_d;
    end
  end

  assign dut_in     = mt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_mt    = fmt_q;

endmodule

// File: tb/tb_uop_minterm_sequencer.sv
// Directed bench: behavioural 2-input DUT models (XNOR, XOR, stuck-1, stuck-0) checked by two
// sequencers, default ERR_W and ERR_W=1, sharing clock, reset and start.
module tb_uop_minterm_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [1:0] dut_in, dut_in1;
  logic       dut_out, dut_out1;
  logic       busy, done, pass, fail_valid;
  logic       busy1, done1, pass1, fail_valid1;
  logic [2:0] err_count;
  logic [0:0] err_count1;
  logic [1:0] fail_mt, fail_mt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // mode 0: XNOR, 1: XOR, 2: stuck at 1, 3: stuck at 0
  function automatic logic gate_model(input logic [1:0] m, input logic [1:0] x);
    case (m)
      2'd0:    return ~(x[1] ^ x[0]);
      2'd1:    return x[1] ^ x[0];
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign dut_out  = gate_model(mode, dut_in);
  assign dut_out1 = gate_model(mode, dut_in1);

  uop_minterm_sequencer #(
    .N_IN  (2),
    .TRUTH (4'b1001),
    .SETTLE(2),
    .ERR_W (3)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_valid(fail_valid),
    .fail_mt   (fail_mt)
  );

  uop_minterm_sequencer #(
    .N_IN  (2),
    .TRUTH (4'b1001),
    .SETTLE(2),
    .ERR_W (1)
  ) u_dut_e1 (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dut_in    (dut_in1),
    .dut_out   (dut_out1),
    .busy      (busy1),
    .done      (done1),
    .pass      (pass1),
    .err_count (err_count1),
    .fail_valid(fail_valid1),
    .fail_mt   (fail_mt1)
  );

  typedef struct {
    logic [1:0] mode;
    int         err;
    int         err1;
    logic       fv;
    logic [1:0] fmt;
    logic       pass;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dut_in"}, dut_in, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_fv"}, fail_valid, 0);
    chk({tag, "_fmt"}, fail_mt, 0);
    chk({tag, "_busy1"}, busy1, 0);
    chk({tag, "_done1"}, done1, 0);
    chk({tag, "_err1"}, err_count1, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t    = $sformatf("v%0d", idx);
    mode = v.mode;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);  // E0
    #1 start = 1'b0;
    chk({t, "_e0_busy"}, busy, 1);
    chk({t, "_e0_done"}, done, 0);
    chk({t, "_e0_dut_in"}, dut_in, 0);
    chk({t, "_e0_err"}, err_count, 0);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (c < 12) chk($sformatf("%s_dut_in_e%0d", t, c), dut_in, c / 3);
      chk($sformatf("%s_busy_e%0d", t, c), busy, (c < 12) ? 1 : 0);
      chk($sformatf("%s_done_e%0d", t, c), done, (c == 12) ? 1 : 0);
    end
    chk({t, "_err"}, err_count, v.err);
    chk({t, "_fv"}, fail_valid, v.fv);
    if (v.fv) chk({t, "_fmt"}, fail_mt, v.fmt);
    chk({t, "_pass"}, pass, v.pass);
    chk({t, "_done1"}, done1, 1);
    chk({t, "_err1"}, err_count1, v.err1);
    chk({t, "_fv1"}, fail_valid1, v.fv);
    if (v.fv) chk({t, "_fmt1"}, fail_mt1, v.fmt);
    chk({t, "_pass1"}, pass1, v.pass);
  endtask

  initial begin
    //            mode   err err1 fv    fmt    pass
    vecs[0] = '{2'd0, 0, 0, 1'b0, 2'd0, 1'b1};  // XNOR matches
    vecs[1] = '{2'd1, 4, 1, 1'b1, 2'd0, 1'b0};  // XOR: every minterm wrong
    vecs[2] = '{2'd2, 2, 1, 1'b1, 2'd1, 1'b0};  // stuck 1: minterms 1,2 wrong
    vecs[3] = '{2'd3, 2, 1, 1'b1, 2'd0, 1'b0};  // stuck 0: minterms 0,3 wrong

    #12;
    chk_all_zero("por");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("idle_busy", busy, 0);

    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // start held through a whole run: one run ends at E12, next one begins at E13
    mode = 2'd1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);  // E0
    repeat (12) @(posedge clk);
    #1;
    chk("hold_e12_done", done, 1);
    chk("hold_e12_busy", busy, 0);
    chk("hold_e12_err", err_count, 4);
    @(posedge clk);  // E13
    #1;
    chk("hold_e13_done", done, 0);
    chk("hold_e13_busy", busy, 1);
    chk("hold_e13_err", err_count, 0);
    chk("hold_e13_fv", fail_valid, 0);
    chk("hold_e13_dut_in", dut_in, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("hold_rerun_done", done, 1);
    chk("hold_rerun_err", err_count, 4);

    // asynchronous reset between edges mid-run
    mode = 2'd0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);  // E0
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2 chk("pre_rst_busy", busy, 1);
    #1 reset = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;
    run_vec(4, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
